temporizador: RTL and testbench

Countdown timer at the far end of the magnetron control path. It consumes the `s`/`r` set/reset commands from the control block and holds the resulting magnetron-on state. While that state is on, it decrements a BCD mm:ss count once per second. It generates the `zero` flag that the control block consumes. Operator keypad digits are loaded into the count while the magnetron is off.

---
 rtl/temporizador_if.sv | 30 +++
 rtl/temporizador.sv | 111 +++++++++++
 tb/tb_temporizador.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/temporizador_if.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_if
// Description : Command, keypad and count/status bundle of the magnetron timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface temporizador_if;
    logic       s;
    logic       r;
    logic       carga;
    logic [3:0] dado_min;
    logic [3:0] dado_dez;
    logic [3:0] dado_uni;
    logic [3:0] min;
    logic [3:0] dez;
    logic [3:0] uni;
    logic       zero;
    logic       magnetron;

    modport master (
        output s, r, carga, dado_min, dado_dez, dado_uni,
        input  min, dez, uni, zero, magnetron
    );

    modport slave (
        input  s, r, carga, dado_min, dado_dez, dado_uni,
        output min, dez, uni, zero, magnetron
    );
endinterface
`default_nettype wire

// File: rtl/temporizador.sv
`default_nettype none
// ============================================================================
// Module      : temporizador
// Description : BCD mm:ss countdown timer holding the magnetron-on state.
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRESC_W       = 8
) (
    input  wire            clk,
    input  wire            clr,
    temporizador_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    localparam logic [PRESC_W-1:0] c_PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         min_q, min_d;
    logic [3:0]         dez_q, dez_d;
    logic [3:0]         uni_q, uni_d;

    logic w_on;
    logic w_zero;
    logic w_load;
    logic w_tick;
    logic w_expire;

    assign w_on     = (state_q == ST_ON);
    assign w_zero   = (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd0);
    assign w_load   = bus.carga && !w_on;
    assign w_tick   = w_on && (presc_q == c_PRESC_LAST);
    assign w_expire = w_tick && (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd1);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_OFF;
            presc_q <= '0;
            min_q   <= 4'd0;
            dez_q   <= 4'd0;
            uni_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            min_q   <= min_d;
            dez_q   <= dez_d;
            uni_q   <= uni_d;
        end
    end

    // Prescaler only advances while heating, so a pause keeps the partial second.
    always_comb begin
        presc_d = presc_q;
        if (w_load) begin
            presc_d = '0;
        end else if (w_on) begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        min_d = min_q;
        dez_d = dez_q;
        uni_d = uni_q;
        if (w_load) begin
            min_d = (bus.dado_min > 4'd9) ? 4'd9 : bus.dado_min;
            dez_d = (bus.dado_dez > 4'd5) ? 4'd5 : bus.dado_dez;
            uni_d = (bus.dado_uni > 4'd9) ? 4'd9 : bus.dado_uni;
        end else if (w_tick) begin
            if (uni_q != 4'd0) begin
                uni_d = uni_q - 4'd1;
            end else begin
                uni_d = 4'd9;
                if (dez_q != 4'd0) begin
                    dez_d = dez_q - 4'd1;
                end else begin
                    dez_d = 4'd5;
                    min_d = min_q - 4'd1;
                end
            end
        end
    end

    // Expiry overrides a held start so the tube never runs at 0:00.
    always_comb begin
        state_d = state_q;
        if (bus.r) begin
            state_d = ST_OFF;
        end else if (w_expire) begin
            state_d = ST_OFF;
        end else if (w_load) begin
            state_d = ST_OFF;
        end else if (bus.s && !w_zero) begin
            state_d = ST_ON;
        end
    end

    assign bus.min       = min_q;
    assign bus.dez       = dez_q;
    assign bus.uni       = uni_q;
    assign bus.zero      = w_zero;
    assign bus.magnetron = w_on;

endmodule
`default_nettype wire

// File: tb/tb_temporizador.sv
`default_nettype none
// ============================================================================
// Module      : tb_temporizador
// Description : Scoreboard bench for temporizador with TICKS_PER_SEC = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temporizador;

    logic clk = 1'b0;
    logic clr = 1'b1;

    temporizador_if bus ();

    temporizador #(
        .TICKS_PER_SEC (4),
        .PRESC_W       (3)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [13:0] q_exp[$];
    string       q_name[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    // Expected image per edge: {min, dez, uni, zero, magnetron}
    initial begin
        logic [13:0] act;
        logic [13:0] exp_v;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                exp_v = q_exp.pop_front();
                nm    = q_name.pop_front();
                act   = {bus.min, bus.dez, bus.uni, bus.zero, bus.magnetron};
                n_vec++;
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got %h:%h:%h z=%b m=%b, want %h:%h:%h z=%b m=%b",
                             nm, act[13:10], act[9:6], act[5:2], act[1], act[0],
                             exp_v[13:10], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    task automatic cyc(input logic c, input logic s, input logic r, input logic ld,
                       input logic [3:0] dm, input logic [3:0] dd, input logic [3:0] du,
                       input logic [3:0] em, input logic [3:0] ed, input logic [3:0] eu,
                       input logic ez, input logic emg, input string nm);
        clr          = c;
        bus.s        = s;
        bus.r        = r;
        bus.carga    = ld;
        bus.dado_min = dm;
        bus.dado_dez = dd;
        bus.dado_uni = du;
        q_exp.push_back({em, ed, eu, ez, emg});
        q_name.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic [3:0] em, input logic [3:0] ed, input logic [3:0] eu,
                        input logic ez, input logic emg, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, em, ed, eu, ez, emg, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s = 1'b0; bus.r = 1'b0; bus.carga = 1'b0;
        bus.dado_min = 4'd0; bus.dado_dez = 4'd0; bus.dado_uni = 4'd0;

        // reset dominates s and carga
        cyc(1, 1, 0, 1, 4'd5, 4'd5, 4'd5, 0, 0, 0, 1, 0, "reset0");
        cyc(1, 1, 0, 1, 4'd5, 4'd5, 4'd5, 0, 0, 0, 1, 0, "reset1");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, "s_at_zero");

        // load with clamping
        cyc(0, 0, 0, 1, 4'd1, 4'd7, 4'd12, 1, 5, 9, 0, 0, "clamp_1_7_12");
        cyc(0, 0, 0, 1, 4'd15, 4'd15, 4'd15, 9, 5, 9, 0, 0, "clamp_all");

        // borrow chain 1:00 -> 0:59 -> 0:57, then r on a tick cycle
        cyc(0, 0, 0, 1, 4'd1, 4'd0, 4'd0, 1, 0, 0, 0, 0, "load_100");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 1, "start_100");
        repeat (3) idle(1, 0, 0, 0, 1, "run_100");
        idle(0, 5, 9, 0, 1, "borrow_059");
        repeat (3) idle(0, 5, 9, 0, 1, "run_059");
        idle(0, 5, 8, 0, 1, "tick_058");
        repeat (3) idle(0, 5, 8, 0, 1, "run_058");
        idle(0, 5, 7, 0, 1, "tick_057");
        repeat (3) idle(0, 5, 7, 0, 1, "run_057");
        cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 5, 6, 0, 0, "r_with_tick");

        // expiry clears magnetron on the same edge
        cyc(0, 0, 0, 1, 4'd0, 4'd0, 4'd2, 0, 0, 2, 0, 0, "load_002");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 2, 0, 1, "start_002");
        repeat (3) idle(0, 0, 2, 0, 1, "run_002");
        idle(0, 0, 1, 0, 1, "tick_001");
        repeat (3) idle(0, 0, 1, 0, 1, "run_001");
        idle(0, 0, 0, 1, 0, "expire");
        repeat (2) idle(0, 0, 0, 1, 0, "hold_000");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, "s_after_expire");

        // pause/resume keeps the partial second; load ignored while on
        cyc(0, 0, 0, 1, 4'd0, 4'd0, 4'd5, 0, 0, 5, 0, 0, "load_005");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 5, 0, 1, "start_005");
        idle(0, 0, 5, 0, 1, "run_005");
        cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 5, 0, 0, "pause");
        repeat (2) idle(0, 0, 5, 0, 0, "paused");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 5, 0, 1, "resume");
        idle(0, 0, 5, 0, 1, "resumed");
        idle(0, 0, 4, 0, 1, "tick_004");
        cyc(0, 0, 0, 1, 4'd9, 4'd9, 4'd9, 0, 0, 4, 0, 1, "carga_while_on");
        repeat (2) idle(0, 0, 4, 0, 1, "run_004");
        idle(0, 0, 3, 0, 1, "tick_003");

        // priority checks
        cyc(0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 3, 0, 0, "s_and_r");
        cyc(0, 1, 0, 1, 4'd0, 4'd3, 4'd2, 0, 3, 2, 0, 0, "carga_beats_s");
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 3, 2, 0, 1, "start_032");
        idle(0, 3, 2, 0, 1, "run_032");
        cyc(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, "clr_mid");
        idle(0, 0, 0, 1, 0, "after_clr");

        if (bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL after_clr_direct: got zero=%b, want zero=1", bus.zero);
        end
        if (bus.magnetron !== 1'b0) begin
            n_fail++;
            $display("FAIL after_clr_direct: got magnetron=%b, want magnetron=0", bus.magnetron);
        end

        @(posedge clk);
        #3;
        if (n_vec == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got 0 vectors checked, want >0");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        if (n_fail != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule
`default_nettype wire
